apb_slave_mem_responder: RTL and testbench
==========================================

APB_SLAVE_MEM_RESPONDER -- requirements
Module: apb_slave_mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning the paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the pwdata/prdata width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of DATA_WIDTH words of storage (power of 2).
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning the byte address of word 0.
REQ-005 SHALL have port pclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port preset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port psel, input, 1 bit: slave select.
REQ-008 SHALL have port penable, input, 1 bit: access phase.
REQ-009 SHALL have port paddr, input, ADDRESS_WIDTH bits: byte address.
REQ-010 SHALL have port pwrite, input, 1 bit: 1 means write, 0 means read.
REQ-011 SHALL have port pstrb, input, DATA_WIDTH/8 bits: write byte-lane strobes.
REQ-012 SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port pprot, input, 3 bits: protection; bit 1 set means non-secure.
REQ-014 SHALL have port wait_cfg, input, 3 bits: number of wait states to insert per transfer, 0 to 7.
REQ-015 SHALL have port pready, output, 1 bit: transfer complete.
REQ-016 SHALL have port prdata, output, DATA_WIDTH bits: read data.
REQ-017 SHALL have port pslverr, output, 1 bit: transfer error.
REQ-018 SHALL have port err_count, output, 8 bits: count of error completions, saturating.

Function
REQ-019 SHALL implement a state machine with two states, IDLE and ACCESS.
REQ-020 SHALL, in IDLE, on psel=1 and penable=0 (setup phase), load a wait counter from wait_cfg, capture the decoded error status, and go to ACCESS.
REQ-021 SHALL, in ACCESS with psel=1 and penable=1, decrement the wait counter each cycle while it is nonzero, with pready=0.
REQ-022 SHALL assert pready combinationally when state=ACCESS, psel=1, penable=1 and the counter is 0; that same edge completes the transfer and returns the state machine to IDLE.
REQ-023 SHALL make a transfer with wait_cfg=N complete in 2+N cycles from the setup cycle; wait_cfg changes after setup SHALL have no effect on the transfer in progress.
REQ-024 SHALL, if psel falls while in ACCESS, return to IDLE with no memory update and no pready pulse.
REQ-025 SHALL ignore psel=1 and penable=1 while in IDLE (protocol violation): pready=0 and no state change.
REQ-026 SHALL accept back-to-back transfers, so a setup phase in the cycle after completion starts a new transfer.
REQ-027 SHALL compute the word index as (paddr-BASE_ADDR)>>log2(DATA_WIDTH/8), truncated to log2(DEPTH) bits.
REQ-028 SHALL flag an error when paddr<BASE_ADDR, when paddr>=BASE_ADDR+DEPTH*DATA_WIDTH/8, or when the low log2(DATA_WIDTH/8) bits of paddr are nonzero.
REQ-029 SHALL also flag an error for a write with pprot[1]=1 to word indices 0 to 3 (secure-only words); reads of those words SHALL be permitted.
REQ-030 SHALL, on an error-free write completion, update only the byte lanes whose pstrb bit is 1; pstrb=0 SHALL complete OKAY with no change.
REQ-031 SHALL drive prdata with the addressed word during the cycle pready=1 of an error-free read, and 0 at all other times.
REQ-032 SHALL drive pslverr=1 only in the pready=1 cycle of an erroring transfer, with no memory update and prdata=0.
REQ-033 SHALL increment err_count on each pslverr completion and hold it at 255 once reached.

Reset
REQ-034 SHALL, while preset_n=0, force state=IDLE, all memory words=0, wait counter=0 and err_count=0, and hold pready, pslverr and prdata at 0.
REQ-035 SHALL abort any in-progress transfer on reset with no write, and after deassertion SHALL accept only a fresh setup phase.

Verification
REQ-036 SHALL verify: write 0xDEADBEEF to BASE+0x10 with pstrb=0xF and wait_cfg=0, then read it -> pready high in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
REQ-037 SHALL verify: write 0x11223344 with pstrb=0x5 over a word holding 0 -> a read returns 0x00220044.
REQ-038 SHALL verify: with wait_cfg=3, a read -> pready low for 3 access cycles and high in cycle 5; changing wait_cfg mid-transfer has no effect.
REQ-039 SHALL verify: accesses to BASE+0x40 (out of range), BASE+0x2 (misaligned) and a write with pprot=3'b010 to BASE+0x0 -> pslverr=1 each time, memory unchanged, err_count=3.
REQ-040 SHALL verify: psel dropped mid-wait with wait_cfg=5, then preset_n asserted during a pending write -> no write, pready never high, all outputs 0 and memory 0 after reset.

Source files
------------

// File: rtl/apb_slave_mem_responder_if.sv
// apb_slave_mem_responder_if: APB bus bundle between a requester and the memory responder.
interface apb_slave_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     psel;
    logic                     penable;
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic                     pwrite;
    logic [DATA_WIDTH/8-1:0]  pstrb;
    logic [DATA_WIDTH-1:0]    pwdata;
    logic [2:0]               pprot;
    logic                     pready;
    logic [DATA_WIDTH-1:0]    prdata;
    logic                     pslverr;
    modport master (
        output psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
        input  pready, prdata, pslverr
    );
    modport slave (
        input  psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_responder.sv
// apb_slave_mem_responder: APB word memory with programmable wait states, address/secure decode and saturating error count.
module apb_slave_mem_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DEPTH         = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                            pclk,
    input  logic                            preset_n,
    apb_slave_mem_responder_if.slave        bus,
    input  logic [2:0]                      wait_cfg,
    output logic [7:0]                      err_count
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN = ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [ADDRESS_WIDTH:0]   LIMIT = {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(DEPTH * BYTES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_err;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_err_cnt;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_err;
    logic                     w_done;

    assign w_off  = bus.paddr - BASE_ADDR;
    assign w_idx  = IDX_W'(w_off >> OFF);
    // Words 0..3 are secure-only for writes; reads stay open to everyone.
    assign w_err  = (bus.paddr < BASE_ADDR) || ({1'b0, bus.paddr} >= LIMIT) ||
                    ((bus.paddr & ALIGN) != '0) ||
                    (bus.pwrite && bus.pprot[1] && 32'(w_idx) < 32'd4);
    assign w_done = (r_state == ACCESS) && bus.psel && bus.penable && (r_cnt == '0);

    assign bus.pready  = w_done;
    assign bus.pslverr = w_done && r_err;
    assign bus.prdata  = (w_done && !r_err && !bus.pwrite) ? r_mem[r_idx] : '0;
    assign err_count   = r_err_cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_err_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == IDLE) begin
            if (bus.psel && !bus.penable) begin
                r_state <= ACCESS;
                r_cnt   <= wait_cfg;
                r_err   <= w_err;
                r_idx   <= w_idx;
            end
        end else if (!bus.psel) begin
            r_state <= IDLE;
        end else if (bus.penable) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 3'd1;
            end else begin
                r_state <= IDLE;
                if (r_err)
                    r_err_cnt <= r_err_cnt + 8'(r_err_cnt != 8'hFF);
                else if (bus.pwrite)
                    for (int b = 0; b < BYTES; b++)
                        if (bus.pstrb[b]) r_mem[r_idx][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// tb_apb_slave_mem_responder: directed APB transfers; a monitor checks every completion against a queue of expected responses.
module tb_apb_slave_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic [2:0] wait_cfg;
    logic [7:0] err_count;
    int         total = 0;
    int         bad = 0;
    logic [32:0] sb [$];

    apb_slave_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_mem_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(BASE)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .bus(bus.slave),
        .wait_cfg(wait_cfg), .err_count(err_count)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitor: every pready cycle must match the oldest expectation; otherwise outputs stay 0.
    always @(negedge pclk) begin
        if (bus.pready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pready: got pready=1 with no transfer pending");
            end else begin
                check("response", {31'd0, bus.pslverr, bus.prdata}, {31'd0, sb.pop_front()});
            end
        end else begin
            check("idle_outputs", {31'd0, bus.pslverr, bus.prdata}, 64'd0);
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [2:0] waits,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int n;
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr; bus.pwrite = wr;
        bus.pwdata = data; bus.pstrb = strb; bus.pprot = prot; wait_cfg = waits;
        sb.push_back({exp_err, exp_rdata});
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        wait_cfg = ~waits;
        n = 2;
        while (n < 12) begin
            @(negedge pclk);
            if (bus.pready) break;
            n++;
        end
        check("latency", 64'(n), 64'(2 + int'(waits)));
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.psel = 0; bus.penable = 0; bus.paddr = 0; bus.pwrite = 0;
        bus.pwdata = 0; bus.pstrb = 0; bus.pprot = 0; wait_cfg = 0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", 64'(bus.pready), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        preset_n = 1'b1;

        xfer(BASE + 32'h10, 1, 32'hDEADBEEF, 4'hF, 3'b000, 3'd0, 0, 32'h0);
        xfer(BASE + 32'h10, 0, 32'h0, 4'hF, 3'b000, 3'd0, 0, 32'hDEADBEEF);
        xfer(BASE + 32'h14, 1, 32'h11223344, 4'h5, 3'b000, 3'd0, 0, 32'h0);
        xfer(BASE + 32'h14, 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'h00220044);
        xfer(BASE + 32'h10, 1, 32'h0, 4'h0, 3'b000, 3'd1, 0, 32'h0);
        xfer(BASE + 32'h10, 0, 32'h0, 4'h0, 3'b000, 3'd3, 0, 32'hDEADBEEF);
        idle();

        xfer(BASE + 32'h40, 0, 32'h0, 4'hF, 3'b000, 3'd0, 1, 32'h0);
        xfer(BASE + 32'h02, 1, 32'h77, 4'hF, 3'b000, 3'd0, 1, 32'h0);
        xfer(BASE, 1, 32'h55, 4'hF, 3'b010, 3'd2, 1, 32'h0);
        idle();
        check("err_count_3", 64'(err_count), 64'd3);
        xfer(BASE, 0, 32'h0, 4'h0, 3'b010, 3'd0, 0, 32'h0);
        xfer(BASE + 32'h3C, 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'h0);
        xfer(BASE - 32'h4, 0, 32'h0, 4'h0, 3'b000, 3'd0, 1, 32'h0);
        xfer(BASE + 32'h18, 1, 32'hCAFEF00D, 4'hF, 3'b010, 3'd1, 0, 32'h0);
        xfer(BASE + 32'h18, 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'hCAFEF00D);
        idle();
        check("err_count_4", 64'(err_count), 64'd4);

        for (int i = 0; i < 252; i++)
            xfer(BASE + 32'h41, 0, 32'h0, 4'h0, 3'b000, 3'd0, 1, 32'h0);
        idle();
        check("err_count_sat", 64'(err_count), 64'd255);

        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 1; bus.paddr = BASE + 32'h10; bus.pwrite = 0;
        repeat (3) begin
            @(negedge pclk);
            check("idle_violation_pready", 64'(bus.pready), 64'd0);
        end
        idle();

        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.paddr = BASE + 32'h1C; bus.pwrite = 1;
        bus.pwdata = 32'h12345678; bus.pstrb = 4'hF; bus.pprot = 0; wait_cfg = 3'd5;
        @(posedge pclk); #1;
        bus.penable = 1;
        repeat (2) begin
            @(negedge pclk);
            check("abort_pready", 64'(bus.pready), 64'd0);
        end
        idle();
        xfer(BASE + 32'h1C, 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'h0);
        xfer(BASE + 32'h10, 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'hDEADBEEF);
        idle();

        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.paddr = BASE + 32'h20; bus.pwrite = 1;
        bus.pwdata = 32'hAAAA5555; bus.pstrb = 4'hF; bus.pprot = 0; wait_cfg = 3'd2;
        @(posedge pclk); #1;
        bus.penable = 1;
        @(negedge pclk);
        check("pending_pready", 64'(bus.pready), 64'd0);
        preset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {30'd0, bus.pready, bus.pslverr, bus.prdata}, 64'd0);
        check("rst_mid_err_count", 64'(err_count), 64'd0);
        repeat (3) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            check("post_rst_no_setup", 64'(bus.pready), 64'd0);
        end
        idle();
        for (int w = 0; w < 16; w++)
            xfer(BASE + 32'(w * 4), 0, 32'h0, 4'h0, 3'b000, 3'd0, 0, 32'h0);
        idle();
        check("final_err_count", 64'(err_count), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
